pc_fetch_unit: RTL

- Instruction-fetch stage driven by the core's one-hot control sequencer.
- Consumes the sequencer's PC-enable and memory-enable pulses.
- Holds and advances the program counter and runs a req/ack read on instruction memory.
- Latches the fetched word for the decode stage.

---
 rtl/pc_fetch_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch stage. Holds the program counter, advances or redirects it
// on the sequencer's PC-enable pulse, and runs a req/ack read of instruction
// memory on the following memory-enable pulse. The fetched word, or a NOP
// after a memory timeout, is latched for the decode stage.
//
// State machine:
//   ST_IDLE  - waiting for an I_enpc pulse; I_enmem alone is the data-phase
//              pulse of the sequencer and is ignored here.
//   ST_ARMED - PC updated, waiting for the I_enmem pulse that starts the read.
//   ST_WAIT  - O_imem_req high with a stable address until ack or timeout.
//
// Every output is driven from a flop. O_busy is a decode of the state register.

module pc_fetch_unit #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter int unsigned      TIMEOUT   = 15,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            I_reset_n,
    input  logic            I_enpc,
    input  logic            I_enmem,
    input  logic            I_branch_taken,
    input  logic [XLEN-1:0] I_branch_target,
    output logic            O_imem_req,
    output logic [XLEN-1:0] O_imem_addr,
    input  logic            I_imem_ack,
    input  logic [XLEN-1:0] I_imem_rdata,
    output logic [XLEN-1:0] O_pc,
    output logic [XLEN-1:0] O_instr,
    output logic            O_instr_valid,
    output logic            O_busy,
    output logic            O_fault
);

    // Value of the wait counter during the last WAIT cycle before a timeout.
    // The counter holds the number of earlier ack-less WAIT cycles, so it
    // reads TIMEOUT-1 in the TIMEOUT-th cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_t;

    // Sequential successor of a PC; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    // Redirect target forced onto a word boundary. Masking rather than
    // slicing keeps every target bit in use.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

    fetch_state_t    state_r;
    fetch_state_t    state_nxt_s;

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] instr_nxt_s;
    logic            valid_r;
    logic            valid_nxt_s;
    logic            req_r;
    logic            req_nxt_s;
    logic            fault_r;
    logic            fault_nxt_s;
    logic            first_fetch_r;
    logic            first_fetch_nxt_s;
    logic [7:0]      wait_cnt_r;
    logic [7:0]      wait_cnt_nxt_s;

    logic            in_wait_s;
    logic            ack_hit_s;
    logic            timeout_hit_s;

    // Completion decode for the current WAIT cycle; an ack in the final
    // allowed cycle takes priority over the timeout.
    always_comb begin
        in_wait_s     = (state_r == ST_WAIT);
        ack_hit_s     = in_wait_s && I_imem_ack;
        timeout_hit_s = in_wait_s && !I_imem_ack && (wait_cnt_r == WAIT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: enpc wins in IDLE, enmem wins in ARMED, and WAIT
    // ignores both sequencer pulses.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (I_enpc) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (I_enmem) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_WAIT: begin
                if (ack_hit_s || timeout_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values. Everything holds unless the current
    // state acts on it.
    always_comb begin
        pc_nxt_s          = pc_r;
        instr_nxt_s       = instr_r;
        valid_nxt_s       = valid_r;
        req_nxt_s         = req_r;
        fault_nxt_s       = fault_r;
        first_fetch_nxt_s = first_fetch_r;
        wait_cnt_nxt_s    = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                req_nxt_s      = 1'b0;
                wait_cnt_nxt_s = 8'd0;
                if (I_enpc) begin
                    // The first fetch after reset uses RESET_PC itself.
                    if (first_fetch_r) begin
                        first_fetch_nxt_s = 1'b0;
                    end else if (I_branch_taken) begin
                        pc_nxt_s = word_align(I_branch_target);
                    end else begin
                        pc_nxt_s = pc_plus4(pc_r);
                    end
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            ST_ARMED: begin
                if (I_enmem) begin
                    req_nxt_s      = 1'b1;
                    wait_cnt_nxt_s = 8'd0;
                end else begin
                    req_nxt_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (ack_hit_s) begin
                    instr_nxt_s    = I_imem_rdata;
                    valid_nxt_s    = 1'b1;
                    req_nxt_s      = 1'b0;
                    wait_cnt_nxt_s = 8'd0;
                end else if (timeout_hit_s) begin
                    // Hand decode a harmless instruction and flag the fault;
                    // the flag stays set until reset.
                    instr_nxt_s    = NOP_INSTR;
                    valid_nxt_s    = 1'b1;
                    req_nxt_s      = 1'b0;
                    fault_nxt_s    = 1'b1;
                    wait_cnt_nxt_s = 8'd0;
                end else begin
                    req_nxt_s      = 1'b1;
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                req_nxt_s      = 1'b0;
                wait_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // Datapath and output registers; reset clears the request at once.
    always_ff @(posedge clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            pc_r          <= RESET_PC;
            instr_r       <= {XLEN{1'b0}};
            valid_r       <= 1'b0;
            req_r         <= 1'b0;
            fault_r       <= 1'b0;
            first_fetch_r <= 1'b1;
            wait_cnt_r    <= 8'd0;
        end else begin
            pc_r          <= pc_nxt_s;
            instr_r       <= instr_nxt_s;
            valid_r       <= valid_nxt_s;
            req_r         <= req_nxt_s;
            fault_r       <= fault_nxt_s;
            first_fetch_r <= first_fetch_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
        end
    end

    assign O_pc          = pc_r;
    assign O_imem_addr   = pc_r;
    assign O_imem_req    = req_r;
    assign O_instr       = instr_r;
    assign O_instr_valid = valid_r;
    assign O_fault       = fault_r;
    assign O_busy        = (state_r != ST_IDLE);

endmodule
